bcd_digit_streamer: RTL

BCD_DIGIT_STREAMER -- requirements
Module: bcd_digit_streamer

---
 rtl/bcd_digit_streamer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bcd_digit_streamer.sv
// bcd_digit_streamer
// Accepts a packed BCD word and streams its digits one per output handshake,
// most significant first. Leading zeros can optionally be skipped. Digits above 9
// are passed through unchanged and flagged on out_err.
module bcd_digit_streamer #(
  parameter int DIGIT    = 2,  // number of packed BCD digits, 1..8
  parameter int SUPPRESS = 1   // 1: skip leading zeros, 0: stream every digit
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIGIT*4-1:0] BCD_code,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_digit,
  output logic               out_last,
  output logic               out_err
);

  // Digit index width: enough to address DIGIT nibbles, never narrower than 1 bit.
  localparam int IW = (DIGIT > 1) ? $clog2(DIGIT) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [DIGIT*4-1:0] word_reg;
  logic [DIGIT*4-1:0] word_next;
  logic [IW-1:0]      idx_reg;
  logic [IW-1:0]      idx_next;

  // Goes high on the first clock edge after reset is released. in_ready stays low
  // while reset is held and until that first edge.
  logic               started_reg;

  // Per-nibble views of the incoming word and of the captured word.
  logic [3:0]         in_nib  [DIGIT];
  logic [DIGIT-1:0]   in_nz;
  logic [3:0]         cur_nib [DIGIT];

  logic [IW-1:0]      start_idx;
  logic [3:0]         cur_digit;
  logic               accept;
  logic               out_fire;

  genvar gi;
  generate
    for (gi = 0; gi < DIGIT; gi++) begin : g_nib
      assign in_nib[gi]  = BCD_code[gi*4 +: 4];
      assign in_nz[gi]   = |in_nib[gi];
      assign cur_nib[gi] = word_reg[gi*4 +: 4];
    end
  endgenerate

  // Start index for a newly captured word. With suppression this is the highest
  // nonzero nibble (any value other than 0 counts, including values above 9).
  // An all-zero word starts at the LSD, so exactly one 0 is emitted.
  always_comb begin
    start_idx = '0;
    if (SUPPRESS == 0) begin
      start_idx = IW'(DIGIT - 1);
    end else begin
      // Ascending scan: the last hit is the most significant nonzero nibble.
      for (int i = 0; i < DIGIT; i++) begin
        if (in_nz[i]) begin
          start_idx = IW'(i);
        end
      end
    end
  end

  // The nibble currently presented. The index always stays below DIGIT.
  assign cur_digit = cur_nib[idx_reg];

  // State, captured word and digit index. Reset drops straight to IDLE, which
  // aborts any word that is being streamed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      word_reg    <= '0;
      idx_reg     <= '0;
      started_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      word_reg    <= word_next;
      idx_reg     <= idx_next;
      started_reg <= 1'b1;
    end
  end

  // Next-state logic and handshake outputs. The captured word and the index only
  // change on a capture or an output handshake, so a stalled digit stays stable.
  always_comb begin
    state_next = state_reg;
    word_next  = word_reg;
    idx_next   = idx_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_digit  = 4'd0;
    out_last   = 1'b0;
    out_err    = 1'b0;
    accept     = 1'b0;
    out_fire   = 1'b0;

    case (state_reg)
      IDLE: begin
        in_ready = started_reg;
        accept   = in_valid && started_reg;
        if (accept) begin
          word_next  = BCD_code;
          idx_next   = start_idx;
          state_next = SEND;
        end
      end

      SEND: begin
        // in_valid is ignored here; the captured word is held until IDLE.
        out_valid = 1'b1;
        out_digit = cur_digit;
        out_last  = (idx_reg == '0);
        out_err   = (cur_digit > 4'd9);
        out_fire  = out_ready;
        if (out_fire) begin
          if (idx_reg == '0) begin
            // Final digit accepted: back to IDLE, index stays at 0 (no wrap).
            state_next = IDLE;
          end else begin
            idx_next = idx_reg - 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
